// File: rtl/gt_cache_pkg.sv
// Shared line/tag types and helpers for the GT cache blocks
// (direct-mapped L1 and its victim cache).
package gt_cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;
    localparam int TAG_W    = ADDR_W - OFFSET_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [LINE_W-1:0] line_t;

    function automatic tag_t tag_of(input addr_t addr);
        tag_t                tag;
        logic [OFFSET_W-1:0] offset_unused;
        {tag, offset_unused} = addr;
        return tag;
    endfunction

    // Byte lanes are little-endian: byte n lives in bits [8n+7:8n].
    function automatic logic [7:0] byte_sel(input line_t line, input logic [OFFSET_W-1:0] offset);
        return line[{offset, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/gt_victim_match.sv
// Fully-associative tag match plus lowest-index free-slot search.
module gt_victim_match
    import gt_cache_pkg::*;
#(
    parameter  int ENTRIES = 4,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] valid_i,
    input  tag_t               tags_i [ENTRIES],
    input  tag_t               query_i,
    output logic               hit_o,
    output logic [IDX_W-1:0]   hit_idx_o,
    output logic [IDX_W-1:0]   free_idx_o,
    output logic               any_free_o
);

    // Scan from the top down so the lowest index is the one left standing.
    always_comb begin
        hit_o      = 1'b0;
        hit_idx_o  = '0;
        free_idx_o = '0;
        any_free_o = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_i[i] && (tags_i[i] == query_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
            if (!valid_i[i]) begin
                any_free_o = 1'b1;
                free_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/gt_victim_cache.sv
// Fully-associative victim cache behind GT_direct_map: captures evicted lines,
// returns them on an L1 miss and frees the entry (swap semantics).
module gt_victim_cache
    import gt_cache_pkg::*;
#(
    parameter  int ENTRIES = 4,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int CNT_W   = IDX_W + 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              evictValid,
    input  logic [ADDR_W-1:0] evictAddr,
    input  logic [LINE_W-1:0] evictData,
    input  logic              lookupValid,
    input  logic [ADDR_W-1:0] lookupAddr,
    output logic              lookupDone,
    output logic              lookupHit,
    output logic [LINE_W-1:0] lookupData,
    output logic [7:0]        dataReturn,
    output logic [CNT_W-1:0]  occupancy
);

    logic [ENTRIES-1:0] valid_q, valid_d;
    tag_t               tag_q  [ENTRIES];
    line_t              data_q [ENTRIES];
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   occ_q, occ_d;

    logic               done_q, hit_q;
    line_t              line_q, line_d;
    logic [7:0]         byte_q, byte_d;

    logic               lk_match, ev_match, ev_any_free, lk_hit;
    logic [IDX_W-1:0]   lk_idx, ev_idx, ev_free_idx, wr_idx;
    logic [IDX_W-1:0]   lk_free_idx_unused;
    logic               lk_any_free_unused;

    gt_victim_match #(.ENTRIES(ENTRIES)) u_lookup_match (
        .valid_i    (valid_q),
        .tags_i     (tag_q),
        .query_i    (tag_of(lookupAddr)),
        .hit_o      (lk_match),
        .hit_idx_o  (lk_idx),
        .free_idx_o (lk_free_idx_unused),
        .any_free_o (lk_any_free_unused)
    );

    gt_victim_match #(.ENTRIES(ENTRIES)) u_evict_match (
        .valid_i    (valid_q),
        .tags_i     (tag_q),
        .query_i    (tag_of(evictAddr)),
        .hit_o      (ev_match),
        .hit_idx_o  (ev_idx),
        .free_idx_o (ev_free_idx),
        .any_free_o (ev_any_free)
    );

    always_comb begin
        lk_hit  = lookupValid && lk_match;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        wr_idx  = '0;
        if (lk_hit) begin
            valid_d[lk_idx] = 1'b0;
        end
        // Same-tag overwrite beats reusing the slot a hit is vacating, which
        // beats a free slot; round-robin replacement only when full.
        if (evictValid) begin
            if (ev_match) begin
                wr_idx = ev_idx;
            end else if (lk_hit) begin
                wr_idx = lk_idx;
            end else if (ev_any_free) begin
                wr_idx = ev_free_idx;
            end else begin
                wr_idx = ptr_q;
                ptr_d  = ptr_q + IDX_W'(1);
            end
            valid_d[wr_idx] = 1'b1;
        end
        occ_d = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            occ_d = occ_d + CNT_W'(valid_d[i]);
        end
        line_d = lk_hit ? data_q[lk_idx] : '0;
        byte_d = byte_sel(line_d, lookupAddr[OFFSET_W-1:0]);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            valid_q <= '0;
            ptr_q   <= '0;
            occ_q   <= '0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            line_q  <= '0;
            byte_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            occ_q   <= occ_d;
            done_q  <= lookupValid;
            if (lookupValid) begin
                hit_q  <= lk_hit;
                line_q <= line_d;
                byte_q <= byte_d;
            end
        end
    end

    // Tag/data storage is qualified by valid_q, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (RST_N && evictValid) begin
            tag_q[wr_idx]  <= tag_of(evictAddr);
            data_q[wr_idx] <= evictData;
        end
    end

    assign lookupDone = done_q;
    assign lookupHit  = hit_q;
    assign lookupData = line_q;
    assign dataReturn = byte_q;
    assign occupancy  = occ_q;

endmodule

// File: tb/tb_gt_victim_cache.sv
// Self-checking bench for gt_victim_cache: directed vector table, then
// randomized traffic against a slot-level reference model.
module tb_gt_victim_cache;
    import gt_cache_pkg::*;

    localparam int ENTRIES = 4;
    localparam int CNT_W   = 3;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              evictValid;
    logic [ADDR_W-1:0] evictAddr;
    logic [LINE_W-1:0] evictData;
    logic              lookupValid;
    logic [ADDR_W-1:0] lookupAddr;
    logic              lookupDone;
    logic              lookupHit;
    logic [LINE_W-1:0] lookupData;
    logic [7:0]        dataReturn;
    logic [CNT_W-1:0]  occupancy;

    always #5 CLK = ~CLK;

    gt_victim_cache #(.ENTRIES(ENTRIES)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .evictValid  (evictValid),
        .evictAddr   (evictAddr),
        .evictData   (evictData),
        .lookupValid (lookupValid),
        .lookupAddr  (lookupAddr),
        .lookupDone  (lookupDone),
        .lookupHit   (lookupHit),
        .lookupData  (lookupData),
        .dataReturn  (dataReturn),
        .occupancy   (occupancy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          ev_v;
        logic [31:0] ev_a;
        line_t       ev_d;
        bit          lk_v;
        logic [31:0] lk_a;
        bit          e_done;
        bit          e_hit;
        line_t       e_data;
        logic [7:0]  e_byte;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t vecs[$];

    // Line k holds byte value k*32+i in byte lane i.
    function automatic line_t mkline(input int k);
        line_t l;
        for (int i = 0; i < 32; i++) l[8*i +: 8] = 8'(k * 32 + i);
        return l;
    endfunction

    function automatic void v_rst();
        vecs.push_back('{1'b1, 1'b0, 32'h0, '0, 1'b0, 32'h0, 1'b0, 1'b0, '0, 8'h00, 3'd0});
    endfunction
    function automatic void v_rst_ev(input logic [31:0] a, input line_t d);
        vecs.push_back('{1'b1, 1'b1, a, d, 1'b0, 32'h0, 1'b0, 1'b0, '0, 8'h00, 3'd0});
    endfunction
    function automatic void v_ev(input logic [31:0] a, input line_t d, input logic [2:0] occ);
        vecs.push_back('{1'b0, 1'b1, a, d, 1'b0, 32'h0, 1'b0, 1'b0, '0, 8'h00, occ});
    endfunction
    function automatic void v_lk(input logic [31:0] a, input bit hit, input line_t d,
                                 input logic [7:0] b, input logic [2:0] occ);
        vecs.push_back('{1'b0, 1'b0, 32'h0, '0, 1'b1, a, 1'b1, hit, d, b, occ});
    endfunction
    function automatic void v_both(input logic [31:0] la, input logic [31:0] ea, input line_t ed,
                                   input bit hit, input line_t d, input logic [7:0] b, input logic [2:0] occ);
        vecs.push_back('{1'b0, 1'b1, ea, ed, 1'b1, la, 1'b1, hit, d, b, occ});
    endfunction

    // Reference model: slots with valid/tag/line and a round-robin pointer.
    bit          m_valid [ENTRIES];
    logic [26:0] m_tag   [ENTRIES];
    line_t       m_line  [ENTRIES];
    int          m_ptr;
    bit          m_done, m_hit;
    line_t       m_data;
    logic [7:0]  m_byte;

    function automatic int m_occ();
        int n = 0;
        for (int i = 0; i < ENTRIES; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    function automatic void model_step(input bit rst, input bit ev_v, input logic [31:0] ev_a,
                                       input line_t ev_d, input bit lk_v, input logic [31:0] lk_a);
        int hit_slot, same_slot, slot;
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
            m_ptr = 0; m_done = 0; m_hit = 0; m_data = '0; m_byte = '0;
            return;
        end
        hit_slot = -1;
        same_slot = -1;
        for (int i = 0; i < ENTRIES; i++) begin
            if (lk_v && m_valid[i] && m_tag[i] == lk_a[31:5]) hit_slot = i;
            if (ev_v && m_valid[i] && m_tag[i] == ev_a[31:5]) same_slot = i;
        end
        m_done = lk_v;
        if (lk_v) begin
            m_hit  = (hit_slot >= 0);
            m_data = m_hit ? m_line[hit_slot] : '0;
            m_byte = m_data[8 * int'(lk_a[4:0]) +: 8];
        end
        if (hit_slot >= 0) m_valid[hit_slot] = 1'b0;
        if (ev_v) begin
            slot = -1;
            if (same_slot >= 0) slot = same_slot;
            else if (hit_slot >= 0) slot = hit_slot;
            else begin
                for (int i = ENTRIES - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
            end
            if (slot < 0) begin
                slot  = m_ptr;
                m_ptr = (m_ptr + 1) % ENTRIES;
            end
            m_valid[slot] = 1'b1;
            m_tag[slot]   = ev_a[31:5];
            m_line[slot]  = ev_d;
        end
    endfunction

    task automatic drive(input bit rst, input bit ev_v, input logic [31:0] ev_a, input line_t ev_d,
                         input bit lk_v, input logic [31:0] lk_a);
        RST_N       = !rst;
        evictValid  = ev_v;
        evictAddr   = ev_a;
        evictData   = ev_d;
        lookupValid = lk_v;
        lookupAddr  = lk_a;
        @(posedge CLK);
        #1;
        RST_N       = 1'b1;
        evictValid  = 1'b0;
        lookupValid = 1'b0;
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    line_t ld;
    line_t rd;
    logic [26:0] tpool [8];

    initial begin
        ld = 256'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666_5555_4444_3333_2222_1111_0000;

        drive(1'b1, 1'b0, 32'h0, '0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h0010_0000, ld, 1'b1, 32'h0010_0000);
        chk("reset done", LINE_W'(lookupDone), '0);
        chk("reset hit", LINE_W'(lookupHit), '0);
        chk("reset data", lookupData, '0);
        chk("reset byte", LINE_W'(dataReturn), '0);
        chk("reset occ", LINE_W'(occupancy), '0);

        // cold miss
        v_lk(32'h0030_0003, 1'b0, '0, 8'h00, 3'd0);
        // fill, hit frees entry, repeat misses
        v_ev(32'h0010_0001, ld, 3'd1);
        v_ev(32'h0020_0002, ld, 3'd2);
        v_ev(32'h0030_0003, ld, 3'd3);
        v_lk(32'h0020_0002, 1'b1, ld, 8'h11, 3'd2);
        v_lk(32'h0020_0002, 1'b0, '0, 8'h00, 3'd2);
        // full: round-robin replacement
        v_rst();
        v_ev(32'h0000_0000, mkline(0), 3'd1);
        v_ev(32'h0000_0020, mkline(1), 3'd2);
        v_ev(32'h0000_0040, mkline(2), 3'd3);
        v_ev(32'h0000_0060, mkline(3), 3'd4);
        v_ev(32'h0230_00F3, mkline(4), 3'd4);
        v_lk(32'h0000_0000, 1'b0, '0, 8'h00, 3'd4);
        v_lk(32'h0230_00E0, 1'b1, mkline(4), 8'h80, 3'd3);
        v_ev(32'h0000_0080, mkline(5), 3'd4);
        v_ev(32'h0000_00A0, mkline(6), 3'd4);
        v_lk(32'h0000_0020, 1'b0, '0, 8'h00, 3'd4);
        v_lk(32'h0000_0040, 1'b1, mkline(2), 8'h40, 3'd3);
        v_lk(32'h0000_00A0, 1'b1, mkline(6), 8'hC0, 3'd2);
        v_lk(32'h0000_0060, 1'b1, mkline(3), 8'h60, 3'd1);
        // same-tag overwrite in place
        v_rst();
        v_ev(32'h0030_0003, mkline(1), 3'd1);
        v_ev(32'h0030_0010, mkline(2), 3'd1);
        v_lk(32'h0030_0003, 1'b1, mkline(2), 8'h43, 3'd0);
        // hit + evict in the same cycle
        v_rst();
        v_ev(32'h0030_0003, mkline(1), 3'd1);
        v_ev(32'h0050_0000, mkline(3), 3'd2);
        v_both(32'h0030_0003, 32'h0040_0000, mkline(2), 1'b1, mkline(1), 8'h23, 3'd2);
        v_lk(32'h0040_0000, 1'b1, mkline(2), 8'h40, 3'd1);
        v_ev(32'h0030_0003, mkline(1), 3'd2);
        v_both(32'h0030_0003, 32'h0030_0003, mkline(4), 1'b1, mkline(1), 8'h23, 3'd2);
        v_lk(32'h0030_0003, 1'b1, mkline(4), 8'h83, 3'd1);
        // mid-stream reset drops the concurrent evict
        v_ev(32'h0070_0000, mkline(5), 3'd2);
        v_rst_ev(32'h0080_0000, mkline(6));
        v_lk(32'h0080_0000, 1'b0, '0, 8'h00, 3'd0);
        v_lk(32'h0070_0000, 1'b0, '0, 8'h00, 3'd0);
        v_lk(32'h0050_0000, 1'b0, '0, 8'h00, 3'd0);

        foreach (vecs[n]) begin
            drive(vecs[n].rst, vecs[n].ev_v, vecs[n].ev_a, vecs[n].ev_d, vecs[n].lk_v, vecs[n].lk_a);
            chk($sformatf("vec%0d done", n), LINE_W'(lookupDone), LINE_W'(vecs[n].e_done));
            chk($sformatf("vec%0d occ", n), LINE_W'(occupancy), LINE_W'(vecs[n].e_occ));
            if (vecs[n].lk_v || vecs[n].rst) begin
                chk($sformatf("vec%0d hit", n), LINE_W'(lookupHit), LINE_W'(vecs[n].e_hit));
                chk($sformatf("vec%0d data", n), lookupData, vecs[n].e_data);
                chk($sformatf("vec%0d byte", n), LINE_W'(dataReturn), LINE_W'(vecs[n].e_byte));
            end
        end

        for (int i = 0; i < 8; i++) tpool[i] = 27'(i * 32'h1234 + 3);
        drive(1'b1, 1'b0, 32'h0, '0, 1'b0, 32'h0);
        model_step(1'b1, 1'b0, 32'h0, '0, 1'b0, 32'h0);
        for (int c = 0; c < 1500; c++) begin
            bit          r_rst, r_ev, r_lk;
            logic [31:0] r_ea, r_la;
            r_rst = ($urandom_range(0, 99) == 0);
            r_ev  = $urandom_range(0, 1) == 1;
            r_lk  = $urandom_range(0, 1) == 1;
            r_ea  = {tpool[$urandom_range(0, 7)], 5'($urandom)};
            r_la  = {tpool[$urandom_range(0, 7)], 5'($urandom)};
            rd    = rand_line();
            drive(r_rst, r_ev, r_ea, rd, r_lk, r_la);
            model_step(r_rst, r_ev, r_ea, rd, r_lk, r_la);
            chk($sformatf("rnd%0d done", c), LINE_W'(lookupDone), LINE_W'(m_done));
            chk($sformatf("rnd%0d hit", c), LINE_W'(lookupHit), LINE_W'(m_hit));
            chk($sformatf("rnd%0d data", c), lookupData, m_data);
            chk($sformatf("rnd%0d byte", c), LINE_W'(dataReturn), LINE_W'(m_byte));
            chk($sformatf("rnd%0d occ", c), LINE_W'(occupancy), LINE_W'(m_occ()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
